// File: rtl/weighted_rr_scheduler_pkg.sv
// Shared encodings for the weighted round-robin output scheduler:
// operating modes and the two-state grant FSM.
package weighted_rr_scheduler_pkg;

    localparam logic [1:0] MODO_RR        = 2'd0;
    localparam logic [1:0] MODO_PESADO    = 2'd1;
    localparam logic [1:0] MODO_PRIORIDAD = 2'd2;
    localparam logic [1:0] MODO_PESADO_B  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_t;

    function automatic logic is_weighted(input logic [1:0] m);
        return (m == MODO_PESADO) || (m == MODO_PESADO_B);
    endfunction

    function automatic logic is_strict(input logic [1:0] m);
        return m == MODO_PRIORIDAD;
    endfunction

endpackage

// File: rtl/weighted_rr_scheduler_finder.sv
// Rotating first-one search: first set bit of mask_i at or after
// start_i, wrapping modulo N.
module rr_next_finder
    import weighted_rr_scheduler_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [2*N-1:0] dbl;

    assign dbl = {mask_i, mask_i};

    // Walk from the far end so the nearest hit is assigned last.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dbl[int'(start_i) + i]) begin
                idx_o   = IW'(int'(start_i) + i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_scheduler.sv
// Weighted round-robin / strict-priority grant logic for the FIFO
// output stage; holds a grant for up to the queue weight in pops.
module weighted_rr_scheduler
    import weighted_rr_scheduler_pkg::*;
#(
    parameter  int QUEUE_QUANTITY = 4,
    parameter  int MAX_WEIGHT     = 64,
    localparam int W              = $clog2(MAX_WEIGHT),
    localparam int IW             = $clog2(QUEUE_QUANTITY)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enb,
    input  logic [1:0]                  mode,
    input  logic [QUEUE_QUANTITY*W-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]   buf_empty,
    input  logic                        pop,
    output logic [IW-1:0]               selector,
    output logic                        selector_enb,
    output logic [W-1:0]                credit
);

    sched_state_t state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic          sel_enb_q, sel_enb_d;
    logic [W-1:0]  credit_q, credit_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [W-1:0]  peso [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] elig;
    logic          weighted;
    logic          strict;
    logic [IW-1:0] sel_next;
    logic [IW-1:0] start;
    logic [IW-1:0] nxt_idx;
    logic          nxt_found;
    logic [W-1:0]  load_credit;
    logic          acc_pop;
    logic          burst_end;
    logic          preempt;

    assign weighted = is_weighted(mode);
    assign strict   = is_strict(mode);

    always_comb begin
        for (int q = 0; q < QUEUE_QUANTITY; q++) begin
            peso[q] = pesos[q*W +: W];
            elig[q] = !buf_empty[q] && (!weighted || (peso[q] != '0));
        end
    end

    // The served queue sits last in rotation from sel_q+1, so it is
    // only re-picked when nothing else is eligible.
    assign sel_next = sel_q + 1'b1;
    assign start    = strict ? '0
                    : (state_q == SERVE) ? sel_next : ptr_q;

    rr_next_finder #(
        .N (QUEUE_QUANTITY)
    ) u_finder (
        .mask_i  (elig),
        .start_i (start),
        .idx_o   (nxt_idx),
        .found_o (nxt_found)
    );

    assign load_credit = weighted ? peso[nxt_idx] : W'(1);
    assign acc_pop     = pop && sel_enb_q;
    assign burst_end   = (acc_pop && (credit_q <= W'(1)))
                       || (buf_empty[sel_q] && !pop);
    assign preempt     = strict && nxt_found && (nxt_idx != sel_q);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sel_enb_d = sel_enb_q;
        credit_d  = credit_q;
        ptr_d     = ptr_q;
        if (enb) begin
            unique case (state_q)
                IDLE: begin
                    if (nxt_found) begin
                        state_d   = SERVE;
                        sel_d     = nxt_idx;
                        sel_enb_d = 1'b1;
                        credit_d  = load_credit;
                    end
                end
                SERVE: begin
                    if (acc_pop && (credit_q != '0)) begin
                        credit_d = credit_q - 1'b1;
                    end
                    if (burst_end || preempt) begin
                        if (burst_end) begin
                            ptr_d = sel_next;
                        end
                        if (nxt_found) begin
                            sel_d    = nxt_idx;
                            credit_d = load_credit;
                        end else begin
                            state_d   = IDLE;
                            sel_enb_d = 1'b0;
                            credit_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            sel_enb_q <= 1'b0;
            credit_q  <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            sel_enb_q <= sel_enb_d;
            credit_q  <= credit_d;
            ptr_q     <= ptr_d;
        end
    end

    assign selector     = sel_q;
    assign selector_enb = sel_enb_q;
    assign credit       = credit_q;

endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// Directed bench for weighted_rr_scheduler: weighted, plain RR,
// strict priority, async reset and enable/pop corners.
module tb_weighted_rr_scheduler;

    localparam int QQ = 4;
    localparam int MW = 64;
    localparam int W  = 6;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic          enb;
    logic [1:0]    mode;
    logic [QQ*W-1:0] pesos;
    logic [QQ-1:0] buf_empty;
    logic          pop;
    logic [IW-1:0] selector;
    logic          selector_enb;
    logic [W-1:0]  credit;

    int tests = 0;
    int fails = 0;

    weighted_rr_scheduler #(
        .QUEUE_QUANTITY (QQ),
        .MAX_WEIGHT     (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .mode         (mode),
        .pesos        (pesos),
        .buf_empty    (buf_empty),
        .pop          (pop),
        .selector     (selector),
        .selector_enb (selector_enb),
        .credit       (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic grant(input string tag, input int s, input int c);
        chk({tag, ".en"}, 32'(selector_enb), 32'd1);
        chk({tag, ".sel"}, 32'(selector), 32'(s));
        chk({tag, ".cr"}, 32'(credit), 32'(c));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    function automatic logic [QQ*W-1:0] pk(input int w0, input int w1,
                                           input int w2, input int w3);
        return {W'(w3), W'(w2), W'(w1), W'(w0)};
    endfunction

    int exp_sel [10] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1};
    int exp_cr  [10] = '{3, 2, 1, 1, 2, 1, 3, 2, 1, 1};

    initial begin
        rst       = 1'b0;
        enb       = 1'b1;
        mode      = 2'd1;
        pesos     = pk(3, 1, 2, 0);
        buf_empty = 4'b1111;
        pop       = 1'b0;
        #3;
        chk("rst.en", 32'(selector_enb), 32'd0);
        chk("rst.sel", 32'(selector), 32'd0);
        chk("rst.cr", 32'(credit), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_empty.en", 32'(selector_enb), 32'd0);

        // weighted RR, all queues backlogged, pop every cycle
        buf_empty = 4'b0000;
        pop       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            grant($sformatf("wrr%0d", i), exp_sel[i], exp_cr[i]);
        end

        // async reset between edges, mid-burst
        #2;
        rst = 1'b0;
        #1;
        chk("arst.en", 32'(selector_enb), 32'd0);
        chk("arst.cr", 32'(credit), 32'd0);
        chk("arst.sel", 32'(selector), 32'd0);
        buf_empty = 4'b1111;
        pop       = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("arst_rel.en", 32'(selector_enb), 32'd0);
        chk("arst_rel.cr", 32'(credit), 32'd0);

        // early empty: q0 weight 5 with 2 words, q1 backlogged
        pesos     = pk(5, 4, 0, 0);
        buf_empty = 4'b1100;
        tick();
        grant("ee.g0", 0, 5);
        pop = 1'b1;
        tick();
        grant("ee.p1", 0, 4);
        tick();
        grant("ee.p2", 0, 3);
        buf_empty = 4'b1101;
        pop       = 1'b0;
        tick();
        grant("ee.q1", 1, 4);
        buf_empty = 4'b1111;
        tick();
        chk("ee.idle.en", 32'(selector_enb), 32'd0);
        chk("ee.idle.sel", 32'(selector), 32'd1);

        // plain RR with gaps
        do_reset();
        mode      = 2'd0;
        buf_empty = 4'b0101;
        pop       = 1'b1;
        tick();
        grant("rr0", 1, 1);
        tick();
        grant("rr1", 3, 1);
        tick();
        grant("rr2", 1, 1);
        tick();
        grant("rr3", 3, 1);
        buf_empty = 4'b1111;
        pop       = 1'b0;
        tick();
        chk("rr.drain.en", 32'(selector_enb), 32'd0);

        // strict priority preemption
        do_reset();
        mode      = 2'd2;
        buf_empty = 4'b1011;
        tick();
        grant("sp.q2", 2, 1);
        tick();
        grant("sp.hold", 2, 1);
        buf_empty = 4'b1010;
        tick();
        grant("sp.pre", 0, 1);
        pop = 1'b1;
        tick();
        grant("sp.keep", 0, 1);
        buf_empty = 4'b1011;
        pop       = 1'b0;
        tick();
        grant("sp.resume", 2, 1);

        // enb freeze, single-queue reload, pop while idle
        do_reset();
        mode      = 2'd1;
        pesos     = pk(4, 1, 1, 1);
        buf_empty = 4'b1110;
        tick();
        grant("en.g", 0, 4);
        pop = 1'b1;
        tick();
        grant("en.p", 0, 3);
        enb = 1'b0;
        tick();
        tick();
        tick();
        grant("en.frz", 0, 3);
        enb = 1'b1;
        tick();
        grant("en.run", 0, 2);
        tick();
        grant("en.run2", 0, 1);
        tick();
        grant("single.reload", 0, 4);
        buf_empty = 4'b1111;
        pop       = 1'b0;
        tick();
        chk("idlepop.pre.en", 32'(selector_enb), 32'd0);
        pop = 1'b1;
        tick();
        tick();
        chk("idlepop.en", 32'(selector_enb), 32'd0);
        chk("idlepop.cr", 32'(credit), 32'd0);
        chk("idlepop.sel", 32'(selector), 32'd0);
        buf_empty = 4'b1110;
        tick();
        grant("idlepop.grant", 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
